// File: rtl/bus_master_arbiter.sv
// Sole master of the shared parallel bus: round-robin arbitration of N_REQ requesters,
// one read/write at a time with read parity check and ACK timeout.
//   state     | meaning
//   S_IDLE    | pick round-robin winner, latch its command
//   S_SETUP   | address (and write data) on bus, strobes high
//   S_STROBE  | strobe low, wait for ACK low or timeout
//   S_RELEASE | strobes high, wait for ACK high or timeout
//   S_DONE    | one-cycle done pulse to owner, grant dropped
module bus_master_arbiter #(
   parameter int N_REQ     = 4,
   parameter int BUS_WIDTH = 8,
   parameter int TIMEOUT   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ-1:0]             req_we,
   input  logic [N_REQ*8-1:0]           req_addr,
   input  logic [N_REQ*BUS_WIDTH-1:0]   req_wdata,
   output logic [N_REQ-1:0]             gnt,
   output logic [N_REQ-1:0]             done,
   output logic                         err,
   output logic [BUS_WIDTH-1:0]         rdata,
   output logic                         bus_rb_n,
   output logic                         bus_wb_n,
   output logic [7:0]                   bus_addr,
   output logic [BUS_WIDTH-1:0]         bus_data_o,
   output logic                         bus_par_o,
   output logic                         bus_oe,
   input  logic [BUS_WIDTH-1:0]         bus_data_i,
   input  logic                         bus_par_i,
   input  logic                         bus_ack_n
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [PW-1:0]        ptr;
   logic [PW-1:0]        win;
   int                   idx;
   logic                 we_q;
   logic [7:0]           addr_q;
   logic [BUS_WIDTH-1:0] wdata_q;
   logic [CW-1:0]        cnt;
   logic                 grant;
   logic                 cnt_load;
   logic                 ack_cap;
   logic                 tmo;

   logic [7:0]           addr_arr  [N_REQ];
   logic [BUS_WIDTH-1:0] wdata_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*8 +: 8];
      assign wdata_arr[g] = req_wdata[g*BUS_WIDTH +: BUS_WIDTH];
   end

   // Scan from ptr+N-1 down to ptr so the first set bit at/after ptr wins last.
   always_comb begin
      win = '0;
      idx = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (req[PW'(idx)]) win = PW'(idx);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      cnt_load  = 1'b0;
      ack_cap   = 1'b0;
      tmo       = 1'b0;
      bus_rb_n  = 1'b1;
      bus_wb_n  = 1'b1;
      bus_oe    = 1'b0;
      done      = '0;
      case (state)
         S_IDLE: begin
            if (|req) begin
               grant     = 1'b1;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            bus_oe    = we_q;
            cnt_load  = 1'b1;
            state_nxt = S_STROBE;
         end
         S_STROBE: begin
            bus_oe   = we_q;
            bus_wb_n = ~we_q;
            bus_rb_n = we_q;
            if (!bus_ack_n) begin
               ack_cap   = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = S_RELEASE;
            end else if (cnt == '0) begin
               tmo       = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (bus_ack_n) begin
               state_nxt = S_DONE;
            end else if (cnt == '0) begin
               tmo       = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = gnt;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus_addr   = addr_q;
   assign bus_data_o = bus_oe ? wdata_q : '0;
   assign bus_par_o  = bus_oe & (^wdata_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         gnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant) begin
         ptr      <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
         gnt      <= '0;
         gnt[win] <= 1'b1;
         we_q     <= req_we[win];
         addr_q   <= addr_arr[win];
         wdata_q  <= wdata_arr[win];
      end else if (state == S_DONE) begin
         gnt <= '0;
      end
   end

   // Timeout down-counter: reloaded on entry to STROBE and RELEASE, saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (cnt_load)    cnt <= CNT_TC;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err   <= 1'b0;
         rdata <= '0;
      end else if (ack_cap) begin
         if (we_q) begin
            err <= 1'b0;
         end else begin
            rdata <= bus_data_i;
            err   <= (^bus_data_i) != bus_par_i;
         end
      end else if (tmo) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Randomised scoreboard bench for bus_master_arbiter: a batch-level round-robin model
// predicts service order, a slave model answers the bus, a monitor checks each done.
module tb_bus_master_arbiter;
   localparam int N  = 4;
   localparam int BW = 8;
   localparam int TO = 16;

   typedef struct {
      int         owner;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      bit         no_ack;
      bit         stuck;
      int         delay;
      int         hold;
      logic [7:0] data;
      bit         bad_par;
      int         t0;
      int         exp_lat;
      logic [7:0] exp_rdata;
      bit         exp_err;
   } txn_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, req_we, gnt, done;
   logic [N*8-1:0]  req_addr;
   logic [N*BW-1:0] req_wdata;
   logic            err;
   logic [BW-1:0]   rdata, bus_data_o, bus_data_i;
   logic            bus_rb_n, bus_wb_n, bus_par_o, bus_oe, bus_par_i, bus_ack_n;
   logic [7:0]      bus_addr;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   model_ptr = 0;
   logic [7:0] last_rdata = 8'h00;
   txn_t cfg [N];
   txn_t sb_q [$];
   txn_t sl_q [$];

   bus_master_arbiter #(.N_REQ(N), .BUS_WIDTH(BW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .bus_rb_n(bus_rb_n), .bus_wb_n(bus_wb_n), .bus_addr(bus_addr),
      .bus_data_o(bus_data_o), .bus_par_o(bus_par_o), .bus_oe(bus_oe),
      .bus_data_i(bus_data_i), .bus_par_i(bus_par_i), .bus_ack_n(bus_ack_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      model_ptr  = 0;
      last_rdata = 8'h00;
      sb_q.delete();
      sl_q.delete();
   endtask

   task automatic set_cfg(input int i, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit no_ack, input bit stuck,
                          input int delay, input int hold, input logic [7:0] data,
                          input bit bad_par);
      cfg[i].owner   = i;
      cfg[i].we      = we;
      cfg[i].addr    = addr;
      cfg[i].wdata   = wdata;
      cfg[i].no_ack  = no_ack;
      cfg[i].stuck   = no_ack ? 1'b0 : stuck;
      cfg[i].delay   = delay;
      cfg[i].hold    = no_ack ? 0 : hold;
      cfg[i].data    = data;
      cfg[i].bad_par = bad_par;
   endtask

   task automatic rand_cfg(input int i);
      int r;
      r = $urandom_range(0, 9);
      set_cfg(i, 1'($urandom), 8'($urandom), 8'($urandom), r == 0, r == 1,
              $urandom_range(0, 4), $urandom_range(0, 3), 8'($urandom),
              $urandom_range(0, 3) == 0);
   endtask

   task automatic hw_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Requests in mask stay high until their done; service order is every set bit
   // once, starting at the model pointer and wrapping.
   task automatic run_batch(input logic [N-1:0] mask);
      logic [N-1:0] pend;
      int   idx, last, budget;
      bit   first;
      txn_t t;
      @(negedge clk);
      first = 1'b1;
      last  = -1;
      for (int k = 0; k < N; k++) begin
         idx = (model_ptr + k) % N;
         if (mask[idx]) begin
            t = cfg[idx];
            if (!t.we && !t.no_ack) last_rdata = t.data;
            t.exp_rdata = last_rdata;
            t.exp_err   = t.no_ack || t.stuck || (!t.we && t.bad_par);
            t.exp_lat   = first ? 4 + (t.no_ack ? TO - 1 : t.delay) + (t.stuck ? TO - 1 : t.hold) : -1;
            t.t0        = cyc;
            first       = 1'b0;
            last        = idx;
            sb_q.push_back(t);
            sl_q.push_back(t);
         end
      end
      if (last >= 0) model_ptr = (last + 1) % N;
      for (int i = 0; i < N; i++) begin
         req_we[i]           = cfg[i].we;
         req_addr[i*8 +: 8]  = cfg[i].addr;
         req_wdata[i*BW +: BW] = cfg[i].wdata;
      end
      req    = mask;
      pend   = mask;
      budget = 0;
      while (pend != '0 && budget < 600) begin
         @(negedge clk);
         pend   = pend & ~done;
         req    = req & ~done;
         budget++;
      end
      if (pend != '0) begin
         n_checks++;
         n_fail++;
         $display("FAIL batch_timeout: pending %b expected none", pend);
         hw_reset();
      end
   endtask

   // Slave model
   int   sph, scnt, hcnt;
   bit   stb;
   txn_t cur;

   task automatic give_ack();
      bus_ack_n  = 1'b0;
      bus_data_i = cur.data;
      bus_par_i  = (^cur.data) ^ cur.bad_par;
   endtask

   initial begin
      bus_ack_n  = 1'b1;
      bus_data_i = '0;
      bus_par_i  = 1'b0;
      sph        = 0;
      forever begin
         @(negedge clk);
         stb = !bus_rb_n || !bus_wb_n;
         if (rst === 1'b1) begin
            sph       = 0;
            bus_ack_n = 1'b1;
         end else begin
            case (sph)
               0: if (stb) begin
                  if (sl_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_strobe: strobe low, expected idle bus");
                     cur.stuck = 1'b0;
                     sph = 4;
                  end else begin
                     cur  = sl_q.pop_front();
                     scnt = 1;
                     hcnt = 0;
                     chk("strobe_type", 32'({bus_wb_n, bus_rb_n}), cur.we ? 32'h1 : 32'h2);
                     chk("bus_addr", 32'(bus_addr), 32'(cur.addr));
                     chk("bus_oe", 32'(bus_oe), 32'(cur.we));
                     if (cur.we) begin
                        chk("bus_data_o", 32'(bus_data_o), 32'(cur.wdata));
                        chk("bus_par_o", 32'(bus_par_o), 32'(^cur.wdata));
                     end
                     chk("gnt_at_strobe", 32'(gnt), 32'(1) << cur.owner);
                     sph = 1;
                     if (!cur.no_ack && cur.delay == 0) begin
                        give_ack();
                        sph = 2;
                     end
                  end
               end
               1: if (stb) begin
                  scnt++;
                  if (!cur.no_ack && scnt == cur.delay + 1) begin
                     give_ack();
                     sph = 2;
                  end
               end else begin
                  chk("strobe_cycles", 32'(scnt), cur.no_ack ? 32'(TO) : 32'(cur.delay + 1));
                  sph = 4;
               end
               2: begin
                  chk("strobe_released", 32'(stb), 32'h0);
                  if (cur.stuck) sph = 4;
                  else if (cur.hold == 0) begin
                     bus_ack_n = 1'b1;
                     sph = 4;
                  end else sph = 3;
               end
               3: begin
                  hcnt++;
                  if (hcnt == cur.hold) begin
                     bus_ack_n = 1'b1;
                     sph = 4;
                  end
               end
               default: if (done != '0) begin
                  bus_ack_n = 1'b1;
                  sph = 0;
               end
            endcase
         end
      end
   end

   // Monitor: invariants every cycle, scoreboard pop on each done pulse
   logic prev_oe  = 1'b0;
   bit   prev_stb = 1'b0;
   txn_t mt;

   initial forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
         chk("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
         chk("strobes_exclusive", 32'(bus_rb_n | bus_wb_n), 32'h1);
         if ((!bus_rb_n || !bus_wb_n) && prev_stb)
            chk("oe_stable_under_strobe", 32'(bus_oe), 32'(prev_oe));
         if (done != '0) begin
            chk("done_eq_gnt", 32'(done), 32'(gnt));
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: done %b with no pending transaction", done);
            end else begin
               mt = sb_q.pop_front();
               chk("done_owner", 32'(done), 32'(1) << mt.owner);
               chk("err", 32'(err), 32'(mt.exp_err));
               chk("rdata", 32'(rdata), 32'(mt.exp_rdata));
               if (mt.exp_lat >= 0) chk("latency", 32'(cyc - mt.t0), 32'(mt.exp_lat));
            end
         end
      end
      prev_oe  = bus_oe;
      prev_stb = !bus_rb_n || !bus_wb_n;
   end

   int wcnt;

   initial begin
      rst       = 1'b0;
      req       = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      #1 rst = 1'b1;
      #2;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_strobes", 32'({bus_rb_n, bus_wb_n}), 32'h3);
      chk("rst_oe", 32'(bus_oe), 32'h0);
      chk("rst_bus_addr", 32'(bus_addr), 32'h0);
      chk("rst_bus_data", 32'({bus_par_o, bus_data_o}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // round robin: all four, then a sparse mask
      for (int i = 0; i < N; i++)
         set_cfg(i, i[0], 8'(8'h10 + i), 8'(8'h50 + i), 0, 0, i, 0, 8'(8'h20 + i), 0);
      run_batch(4'b1111);
      for (int i = 0; i < N; i++) rand_cfg(i);
      cfg[1].no_ack = 0; cfg[1].stuck = 0;
      cfg[3].no_ack = 0; cfg[3].stuck = 0;
      run_batch(4'b1010);

      // single zero-wait write, then reads with good and bad parity
      set_cfg(0, 1, 8'h3C, 8'hA5, 0, 0, 0, 0, 8'h00, 0);
      run_batch(4'b0001);
      set_cfg(1, 0, 8'h44, 8'h00, 0, 0, 0, 0, 8'h07, 0);
      run_batch(4'b0010);
      set_cfg(1, 0, 8'h45, 8'h00, 0, 0, 1, 1, 8'h07, 1);
      run_batch(4'b0010);

      // strobe timeout, then stuck ACK in release
      set_cfg(2, 0, 8'h80, 8'h00, 1, 0, 0, 0, 8'hEE, 0);
      run_batch(4'b0100);
      chk("rb_back_high", 32'(bus_rb_n), 32'h1);
      set_cfg(3, 0, 8'h81, 8'h00, 0, 1, 2, 0, 8'h5A, 0);
      run_batch(4'b1000);

      // reset while a write strobe is low
      set_cfg(0, 1, 8'hC3, 8'h3C, 1, 0, 0, 0, 8'h00, 0);
      sl_q.push_back(cfg[0]);
      @(negedge clk);
      req_we[0]        = 1'b1;
      req_addr[7:0]    = 8'hC3;
      req_wdata[BW-1:0] = 8'h3C;
      req = 4'b0001;
      wcnt = 0;
      while (bus_wb_n !== 1'b0 && wcnt < 20) begin
         @(negedge clk);
         wcnt++;
      end
      chk("wb_low_before_reset", 32'(bus_wb_n), 32'h0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_strobes", 32'({bus_rb_n, bus_wb_n}), 32'h3);
      chk("midrst_oe", 32'(bus_oe), 32'h0);
      chk("midrst_gnt", 32'(gnt), 32'h0);
      chk("midrst_bus_addr", 32'(bus_addr), 32'h0);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) rand_cfg(i);
      run_batch(4'b0101);
      rand_cfg(2);
      run_batch(4'b0100);

      for (int b = 0; b < 40; b++) begin
         for (int i = 0; i < N; i++) rand_cfg(i);
         run_batch(4'($urandom_range(1, 15)));
      end

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL leftover_txns: %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
